// File: rtl/alu_writeback.sv
// alu_writeback: one-entry writeback stage after the ALU.
// Commits results to A/B, updates CCR, tracks errors, evaluates branches.
module alu_writeback #(
  parameter logic [3:0] CCR_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_result,
  input  logic [3:0] in_nzvc,
  input  logic [3:0] in_op,
  input  logic       in_dest,
  input  logic       in_wr_en,
  input  logic       hold,
  input  logic       ld_valid,
  input  logic       ld_dest,
  input  logic [7:0] ld_data,
  output logic       ld_ack,
  output logic [7:0] reg_a,
  output logic [7:0] reg_b,
  output logic [3:0] ccr,
  output logic       commit_valid,
  input  logic [3:0] br_cond,
  output logic       br_taken,
  output logic       err,
  input  logic       err_clr
);

  typedef struct packed {
    logic [7:0] result;
    logic [3:0] nzvc;
    logic [3:0] op;
    logic       dest;
    logic       wr_en;
  } s1_t;

  s1_t  s1;
  logic s1_valid;

  logic accept;
  logic commit;
  logic is_undef;
  logic is_dz;
  logic is_cmp;
  logic c_err;
  logic c_wr;
  logic c_ccr;
  logic wr_a;
  logic wr_b;
  logic ld_a;
  logic ld_b;

  assign in_ready = !reset && (!s1_valid || !hold);
  assign accept   = in_valid && in_ready;
  assign commit   = s1_valid && !hold;

  assign is_undef = (s1.op >= 4'hA);
  assign is_cmp   = (s1.op == 4'h5);
  assign is_dz    = ((s1.op == 4'h3) || (s1.op == 4'h4)) &&
                    (s1.nzvc == 4'hF) && (s1.result == 8'hFF);

  assign c_err = commit && (is_undef || is_dz);
  assign c_ccr = commit && !is_undef;
  assign c_wr  = commit && s1.wr_en &&
                 !is_undef && !is_dz && !is_cmp;

  assign wr_a = c_wr && !s1.dest;
  assign wr_b = c_wr && s1.dest;

  // A load yields only to a commit writing the same register.
  assign ld_ack = !reset && ld_valid &&
                  !(c_wr && (s1.dest == ld_dest));
  assign ld_a = ld_ack && !ld_dest;
  assign ld_b = ld_ack && ld_dest;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1.result <= in_result;
      s1.nzvc   <= in_nzvc;
      s1.op     <= in_op;
      s1.dest   <= in_dest;
      s1.wr_en  <= in_wr_en;
      s1_valid  <= 1'b1;
    end else if (commit) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_a <= 8'h00;
      reg_b <= 8'h00;
    end else begin
      if (wr_a)
        reg_a <= s1.result;
      else if (ld_a)
        reg_a <= ld_data;
      if (wr_b)
        reg_b <= s1.result;
      else if (ld_b)
        reg_b <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ccr          <= CCR_RESET;
      commit_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      commit_valid <= commit;
      if (c_ccr)
        ccr <= is_dz ? 4'hF : s1.nzvc;
      if (c_err)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

  logic fn;
  logic fz;
  logic fv;
  logic fc;

  assign fn = ccr[3];
  assign fz = ccr[2];
  assign fv = ccr[1];
  assign fc = ccr[0];

  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      4'h0: br_taken = 1'b1;
      4'h1: br_taken = 1'b0;
      4'h2: br_taken = fz;
      4'h3: br_taken = !fz;
      4'h4: br_taken = fn;
      4'h5: br_taken = !fn;
      4'h6: br_taken = fv;
      4'h7: br_taken = !fv;
      4'h8: br_taken = fc;
      4'h9: br_taken = !fc;
      4'hA: br_taken = !fc && !fz;
      4'hB: br_taken = fc || fz;
      4'hC: br_taken = (fn == fv);
      4'hD: br_taken = (fn != fv);
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed tests for alu_writeback.
// Inputs change 1ns after posedge; outputs checked before next edge.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic [3:0] in_nzvc;
  logic [3:0] in_op;
  logic       in_dest;
  logic       in_wr_en;
  logic       hold;
  logic       ld_valid;
  logic       ld_dest;
  logic [7:0] ld_data;
  logic       ld_ack;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic [3:0] ccr;
  logic       commit_valid;
  logic [3:0] br_cond;
  logic       br_taken;
  logic       err;
  logic       err_clr;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  alu_writeback #(.CCR_RESET(4'h0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_nzvc(in_nzvc),
    .in_op(in_op), .in_dest(in_dest),
    .in_wr_en(in_wr_en), .hold(hold),
    .ld_valid(ld_valid), .ld_dest(ld_dest),
    .ld_data(ld_data), .ld_ack(ld_ack),
    .reg_a(reg_a), .reg_b(reg_b), .ccr(ccr),
    .commit_valid(commit_valid),
    .br_cond(br_cond), .br_taken(br_taken),
    .err(err), .err_clr(err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [7:0] res,
                       input logic [3:0] f,
                       input logic d,
                       input logic w);
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_nzvc   = f;
    in_dest   = d;
    in_wr_en  = w;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 0; in_result = 0; in_nzvc = 0;
    in_op = 0; in_dest = 0; in_wr_en = 0;
    hold = 0; ld_valid = 1; ld_dest = 0;
    ld_data = 8'hAA; br_cond = 0; err_clr = 0;
    tick(); tick();
    total++;
    if (in_ready !== 1'b0 || ld_ack !== 1'b0)
      $display("FAIL reset_comb rdy=%b ack=%b want 0 0",
               in_ready, ld_ack);
    else pass_cnt++;
    ld_valid = 0;
    reset = 0;
    #1;
    total++;
    if (reg_a !== 8'h00 || reg_b !== 8'h00 ||
        ccr !== 4'h0 || err !== 1'b0 ||
        commit_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_state a=%h b=%h ccr=%h err=%b cv=%b rdy=%b",
               reg_a, reg_b, ccr, err, commit_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    drive(4'h0, 8'h3C, 4'h0, 1'b0, 1'b1);
    tick();
    in_valid = 0;
    total++;
    if (reg_a !== 8'h00 || commit_valid !== 1'b0)
      $display("FAIL basic_lat a=%h cv=%b want 00 0",
               reg_a, commit_valid);
    else pass_cnt++;
    tick();
    total++;
    if (reg_a !== 8'h3C || ccr !== 4'h0 || commit_valid !== 1'b1)
      $display("FAIL basic_commit a=%h ccr=%h cv=%b want 3c 0 1",
               reg_a, ccr, commit_valid);
    else pass_cnt++;
    tick();
    total++;
    if (commit_valid !== 1'b0)
      $display("FAIL basic_pulse cv=%b want 0", commit_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    ld_valid = 1; ld_dest = 1; ld_data = 8'h77;
    tick();
    ld_valid = 0;
    total++;
    if (reg_b !== 8'h77)
      $display("FAIL b2b_preload b=%h want 77", reg_b);
    else pass_cnt++;
    drive(4'h1, 8'h00, 4'b0100, 1'b1, 1'b1);
    tick();
    drive(4'h5, 8'h55, 4'b0000, 1'b1, 1'b1);
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL b2b_ready rdy=%b want 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 0;
    br_cond = 4'h2;
    #1;
    total++;
    if (reg_b !== 8'h00 || ccr !== 4'b0100 || br_taken !== 1'b1)
      $display("FAIL b2b_first b=%h ccr=%h tk=%b want 00 4 1",
               reg_b, ccr, br_taken);
    else pass_cnt++;
    tick();
    br_cond = 4'h3;
    #1;
    total++;
    if (reg_b !== 8'h00 || ccr !== 4'h0 || br_taken !== 1'b1 ||
        commit_valid !== 1'b1)
      $display("FAIL b2b_cmp b=%h ccr=%h tk=%b cv=%b want 00 0 1 1",
               reg_b, ccr, br_taken, commit_valid);
    else pass_cnt++;
  endtask

  task automatic test_divzero();
    drive(4'h3, 8'hFF, 4'hF, 1'b0, 1'b1);
    tick();
    in_valid = 0;
    tick();
    br_cond = 4'h8;
    #1;
    total++;
    if (reg_a !== 8'h3C || ccr !== 4'hF || err !== 1'b1 ||
        br_taken !== 1'b1)
      $display("FAIL dz a=%h ccr=%h err=%b tk=%b want 3c f 1 1",
               reg_a, ccr, err, br_taken);
    else pass_cnt++;
    drive(4'h4, 8'hFF, 4'hF, 1'b0, 1'b1);
    tick();
    in_valid = 0;
    err_clr = 1;
    tick();
    total++;
    if (err !== 1'b1 || reg_a !== 8'h3C)
      $display("FAIL dz_setwins err=%b a=%h want 1 3c", err, reg_a);
    else pass_cnt++;
    tick();
    err_clr = 0;
    total++;
    if (err !== 1'b0)
      $display("FAIL err_clr err=%b want 0", err);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    hold = 1;
    drive(4'h0, 8'h5A, 4'b1000, 1'b0, 1'b1);
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL hold_empty rdy=%b want 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 1'b0 || commit_valid !== 1'b0 ||
          reg_a !== 8'h3C)
        $display("FAIL hold_%0d rdy=%b cv=%b a=%h want 0 0 3c",
                 i, in_ready, commit_valid, reg_a);
      else pass_cnt++;
      tick();
    end
    hold = 0;
    #1;
    total++;
    if (in_ready !== 1'b1 || reg_a !== 8'h3C)
      $display("FAIL hold_rel rdy=%b a=%h want 1 3c", in_ready, reg_a);
    else pass_cnt++;
    tick();
    total++;
    if (reg_a !== 8'h5A || ccr !== 4'b1000 || commit_valid !== 1'b1)
      $display("FAIL hold_commit a=%h ccr=%h cv=%b want 5a 8 1",
               reg_a, ccr, commit_valid);
    else pass_cnt++;
  endtask

  task automatic test_load_conflict();
    drive(4'h0, 8'h11, 4'h0, 1'b0, 1'b1);
    tick();
    in_valid = 0;
    ld_valid = 1; ld_dest = 0; ld_data = 8'h99;
    #1;
    total++;
    if (ld_ack !== 1'b0)
      $display("FAIL ld_same ack=%b want 0", ld_ack);
    else pass_cnt++;
    tick();
    ld_valid = 0;
    total++;
    if (reg_a !== 8'h11)
      $display("FAIL ld_same_val a=%h want 11", reg_a);
    else pass_cnt++;
    drive(4'h0, 8'h22, 4'h0, 1'b0, 1'b1);
    tick();
    in_valid = 0;
    ld_valid = 1; ld_dest = 1; ld_data = 8'h66;
    #1;
    total++;
    if (ld_ack !== 1'b1)
      $display("FAIL ld_other ack=%b want 1", ld_ack);
    else pass_cnt++;
    tick();
    ld_valid = 0;
    total++;
    if (reg_a !== 8'h22 || reg_b !== 8'h66 || ccr !== 4'h0)
      $display("FAIL ld_both a=%h b=%h ccr=%h want 22 66 0",
               reg_a, reg_b, ccr);
    else pass_cnt++;
  endtask

  task automatic test_undef();
    drive(4'hC, 8'h44, 4'hF, 1'b0, 1'b1);
    tick();
    in_valid = 0;
    tick();
    total++;
    if (reg_a !== 8'h22 || reg_b !== 8'h66 || ccr !== 4'h0 ||
        err !== 1'b1 || commit_valid !== 1'b1)
      $display("FAIL undef a=%h b=%h ccr=%h err=%b cv=%b",
               reg_a, reg_b, ccr, err, commit_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive(4'h0, 8'h77, 4'b0010, 1'b1, 1'b1);
    tick();
    in_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    #1;
    total++;
    if (reg_a !== 8'h00 || reg_b !== 8'h00 || ccr !== 4'h0 ||
        err !== 1'b0 || commit_valid !== 1'b0)
      $display("FAIL rst_mid a=%h b=%h ccr=%h err=%b cv=%b",
               reg_a, reg_b, ccr, err, commit_valid);
    else pass_cnt++;
    tick();
    total++;
    if (reg_b !== 8'h00 || ccr !== 4'h0 || commit_valid !== 1'b0)
      $display("FAIL rst_discard b=%h ccr=%h cv=%b want 00 0 0",
               reg_b, ccr, commit_valid);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    logic [15:0] exp_tk;
    drive(4'h2, 8'h80, 4'b1010, 1'b0, 1'b0);
    tick();
    in_valid = 0;
    tick();
    exp_tk = 16'h1659;
    for (int i = 0; i < 16; i++) begin
      br_cond = i[3:0];
      #1;
      total++;
      if (br_taken !== exp_tk[i])
        $display("FAIL br_nv cond=%h tk=%b want %b",
                 i, br_taken, exp_tk[i]);
      else pass_cnt++;
    end
    drive(4'h6, 8'h00, 4'b0101, 1'b0, 1'b0);
    tick();
    in_valid = 0;
    tick();
    exp_tk = 16'h19A5;
    for (int i = 0; i < 16; i++) begin
      br_cond = i[3:0];
      #1;
      total++;
      if (br_taken !== exp_tk[i])
        $display("FAIL br_zc cond=%h tk=%b want %b",
                 i, br_taken, exp_tk[i]);
      else pass_cnt++;
    end
    total++;
    if (reg_a !== 8'h00)
      $display("FAIL flags_only a=%h want 00", reg_a);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_divzero();
    test_hold();
    test_load_conflict();
    test_undef();
    test_reset_mid();
    test_branch();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback and condition-code stage directly downstream of the 8-bit ALU. It takes each ALU result, its NZVC flags and its operation code through a valid/ready handshake and holds them in a one-entry pipeline register. On commit it writes the result into accumulator A or B, which feed the ALU operand inputs, and updates the condition-code register (CCR). It keeps a sticky error flag for divide/modulo-by-zero and undefined opcodes. Branch decisions are evaluated from the committed CCR.

## Interface
Parameters:
- CCR_RESET, 4'h0, CCR value after reset, bit order {N,Z,V,C}

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  ALU result presented
- in_ready  out  1  stage can accept this cycle
- in_result  in  8  ALU Result
- in_nzvc  in  4  ALU flags {N,Z,V,C}
- in_op  in  4  ALU operation select that produced the result
- in_dest  in  1  destination accumulator: 0 = A, 1 = B
- in_wr_en  in  1  write result to destination (0 = flags only)
- hold  in  1  controller stall; freezes commit
- ld_valid  in  1  external (memory) load request
- ld_dest  in  1  load destination: 0 = A, 1 = B
- ld_data  in  8  load value
- ld_ack  out  1  load performed this cycle
- reg_a  out  8  accumulator A
- reg_b  out  8  accumulator B
- ccr  out  4  committed {N,Z,V,C}
- commit_valid  out  1  one-cycle pulse marking a commit at this edge
- br_cond  in  4  branch condition code
- br_taken  out  1  condition evaluated on ccr (combinational)
- err  out  1  sticky error
- err_clr  in  1  clears err

## Operation
- Stage register s1 holds {result, nzvc, op, dest, wr_en} and s1_valid.
- in_ready = !reset && (!s1_valid || !hold).
- Accept: in_valid && in_ready. The inputs load into s1 and s1_valid is set.
- Commit: s1_valid && !hold. If there is no accept in the same cycle, s1_valid clears.
- Commit actions, by s1.op:
  - op 0–4, 6–9, normal: ccr <= s1.nzvc. If wr_en is set, the destination register <= s1.result.
  - op 3/4 with s1.nzvc == 4'hF and s1.result == 8'hFF (division by zero): ccr <= 4'hF. The register write is suppressed and err is set.
  - op 5 (compare): ccr <= s1.nzvc. The register is never written, regardless of wr_en.
  - op A–F (undefined): no register or CCR change; err is set.
- commit_valid is registered high for the cycle after a commit edge, including the error cases.
- Load: when ld_valid is high and the cycle is not a commit that writes the same register, ld_dest register <= ld_data and ld_ack = 1. Otherwise ld_ack = 0 and the requester retries. A load never touches the CCR.
- err: set on an error commit; err_clr clears it. If both happen in the same cycle, set wins.
- br_taken by br_cond:
  - 0: always
  - 1: never
  - 2: Z
  - 3: !Z
  - 4: N
  - 5: !N
  - 6: V
  - 7: !V
  - 8: C
  - 9: !C
  - A: !C && !Z
  - B: C || Z
  - C: N == V
  - D: N != V
  - E/F: never

## Timing
- Reset values: reg_a = 0, reg_b = 0, ccr = CCR_RESET, err = 0, s1_valid = 0, commit_valid = 0, in_ready = 0, ld_ack = 0. Reset overrides any accept, commit or load in the same cycle.
- Latency: accept at edge k, commit at edge k+1 if hold is low. The new reg/ccr values are visible after edge k+1.
- Throughput: one result per cycle with hold low; an accept and a commit happen in the same cycle back to back.
- While hold is high with s1 full: s1 is stable, in_ready = 0, and the registers are unchanged except through loads.
- Hold asserted while s1 is empty: in_ready stays 1. The accepted entry waits in s1.
- in_ready, ld_ack and br_taken are combinational. br_taken reflects ccr only, never the pending s1 entry.
- Reset asserted mid-operation discards the pending s1 entry. It is not committed.

## Test plan
- Reset, then accept {result=8'h3C, nzvc=0, op=0, dest=A, wr_en=1} -> reg_a = 8'h3C and ccr = 4'h0 after the second edge; commit_valid pulses once.
- Back-to-back: op 1 result 8'h00 nzvc 4'b0100 to B, then op 5 nzvc 4'b0000 with wr_en = 1 -> reg_b = 0 and ccr = 4'b0100, then ccr = 0 with reg_b unchanged; br_cond 2 then 3 gives taken 1 then 1.
- Divide by zero: op 3, result 8'hFF, nzvc 4'hF, dest A -> reg_a unchanged, ccr = 4'hF, err = 1; err_clr in the same cycle as a second error leaves err = 1.
- hold high for 3 cycles with s1 full -> in_ready = 0, no commit; on hold release, commit on the next edge and in_ready returns to 1.
- Load to A in the same cycle as a commit writing A -> ld_ack = 0, reg_a = commit value. Load to B in the same cycle -> ld_ack = 1 and both writes occur.
- Undefined op 4'hC -> no reg/ccr change, err = 1. Reset asserted with s1 full -> outputs return to reset values and no commit occurs.
